// File: rtl/dds_keyer_if.sv
// Control and sample bundle between the config/keying front-end and the DDS keyer.
// master drives configuration and keying; slave produces the DAC code.
interface dds_keyer_if #(
    parameter int ACC_W  = 24,
    parameter int NUM_TW = 4,
    parameter int DAC_W  = 8
);
    localparam int AW = $clog2(NUM_TW);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [ACC_W-1:0] cfg_data;
    logic [1:0]       mode;
    logic             en;
    logic             data_in;
    logic [AW-1:0]    sym;
    logic             sync_clr;
    logic [DAC_W-1:0] dac;
    logic             active;

    modport master (
        output cfg_we, cfg_addr, cfg_data, mode, en, data_in, sym, sync_clr,
        input  dac, active
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, mode, en, data_in, sym, sync_clr,
        output dac, active
    );
endinterface

// File: rtl/dds_keyer.sv
// Continuous-phase DDS with a tuning-word register file, OOK/BFSK/M-FSK/CW keying
// and a linear amplitude ramp, producing an offset-binary DAC code every clock.
module dds_keyer #(
    parameter int ACC_W     = 24,
    parameter int PHASE_W   = 8,
    parameter int DAC_W     = 8,
    parameter int G_W       = 8,
    parameter int NUM_TW    = 4,
    parameter int RAMP_STEP = 1
) (
    input logic        clk,
    input logic        rst_n,
    dds_keyer_if.slave bus
);
    localparam int AW      = $clog2(NUM_TW);
    localparam int QW      = PHASE_W - 2;
    localparam int QN      = 2 ** QW;
    localparam int FULL    = 2 ** G_W;
    localparam int AMP     = 2 ** (DAC_W - 1) - 1;
    localparam int PROD_W  = DAC_W + G_W + 2;
    localparam real PI_HALF = 1.5707963267948966;
    localparam logic [DAC_W-1:0] OFFSET = {1'b1, {(DAC_W-1){1'b0}}};

    localparam logic [1:0] MODE_OOK  = 2'b00;
    localparam logic [1:0] MODE_BFSK = 2'b01;
    localparam logic [1:0] MODE_MFSK = 2'b10;

    // Quarter-wave entry at the half-sample point so the mirrored quadrants line up.
    function automatic logic signed [DAC_W-1:0] quarter_entry(input int i);
        real x;
        real term;
        real sum;
        x    = PI_HALF * (real'(i) + 0.5) / real'(QN);
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return DAC_W'($rtoi(real'(AMP) * sum + 0.5));
    endfunction

    function automatic logic [G_W:0] ramp_gain(input logic [G_W:0] g, input logic up);
        int gi;
        gi = int'(g);
        if (up) begin
            gi = gi + RAMP_STEP;
            if (gi > FULL) gi = FULL;
        end else begin
            gi = gi - RAMP_STEP;
            if (gi < 0) gi = 0;
        end
        return (G_W + 1)'(gi);
    endfunction

    // Full-width signed product, floor shift, then re-centre to offset binary.
    function automatic logic [DAC_W-1:0] scale_sample(input logic signed [DAC_W-1:0] s,
                                                      input logic [G_W:0] g);
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shifted;
        prod    = s * $signed({1'b0, g});
        shifted = prod >>> G_W;
        return DAC_W'(shifted) + OFFSET;
    endfunction

    logic signed [DAC_W-1:0] quarter [QN];

    for (genvar i = 0; i < QN; i++) begin : g_lut
        assign quarter[i] = quarter_entry(i);
    end

    logic [ACC_W-1:0]        tw [NUM_TW];
    logic [ACC_W-1:0]        tw_sel;
    logic [ACC_W-1:0]        acc_p0;
    logic [PHASE_W-1:0]      phase;
    logic [1:0]              quadrant;
    logic [QW-1:0]           idx;
    logic signed [DAC_W-1:0] mag;
    logic signed [DAC_W-1:0] sample_p0;
    logic signed [DAC_W-1:0] sample_p1;
    logic                    key_on;
    logic [G_W:0]            gain_next;
    logic [G_W:0]            gain_p1;
    logic                    active_p1;
    logic [DAC_W-1:0]        dac_p2;

    always_comb begin
        tw_sel = tw[0];
        case (bus.mode)
            MODE_BFSK: tw_sel = tw[AW'(bus.data_in)];
            MODE_MFSK: tw_sel = tw[bus.sym];
            default:   tw_sel = tw[0];
        endcase
    end

    assign key_on    = bus.en && ((bus.mode != MODE_OOK) || bus.data_in);
    assign gain_next = ramp_gain(gain_p1, key_on);

    assign phase     = acc_p0[ACC_W-1 -: PHASE_W];
    assign quadrant  = phase[PHASE_W-1 -: 2];
    assign idx       = quadrant[0] ? ~phase[QW-1:0] : phase[QW-1:0];
    assign mag       = quarter[idx];
    assign sample_p0 = quadrant[1] ? -mag : mag;

    // Stage 0: tuning-word file and phase accumulator (wrap is modular).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TW; i++) tw[i] <= '0;
            acc_p0 <= '0;
        end else begin
            if (bus.cfg_we) tw[bus.cfg_addr] <= bus.cfg_data;
            acc_p0 <= bus.sync_clr ? '0 : acc_p0 + tw_sel;
        end
    end

    // Stage 1: signed LUT sample, alongside the gain it will be scaled by.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_p1 <= '0;
            gain_p1   <= '0;
            active_p1 <= 1'b0;
        end else begin
            sample_p1 <= sample_p0;
            gain_p1   <= gain_next;
            active_p1 <= (gain_next != '0);
        end
    end

    // Stage 2: gain-scaled offset-binary DAC code.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dac_p2 <= OFFSET;
        end else begin
            dac_p2 <= scale_sample(sample_p1, gain_p1);
        end
    end

    assign bus.dac    = dac_p2;
    assign bus.active = active_p1;
endmodule

// File: tb/tb_dds_keyer.sv
// Randomised bench for dds_keyer against a cycle-level arithmetic model of the tone,
// keying ramp and tuning-word file.
module tb_dds_keyer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dds_keyer_if #(.ACC_W(24), .NUM_TW(4), .DAC_W(8)) bus ();

    dds_keyer #(
        .ACC_W(24), .PHASE_W(8), .DAC_W(8), .G_W(8), .NUM_TW(4), .RAMP_STEP(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain arithmetic on phase, gain and tuning words.
    bit [23:0] tw_m [4];
    bit [23:0] acc_m;
    bit [23:0] tsel;
    int        s_m;
    int        gain_m;
    int        target;
    int        dac_m;
    bit        active_m;

    function automatic int sine_ref(input int p);
        real x;
        int  m;
        x = $sin(2.0 * 3.14159265358979323846 * (real'(p) + 0.5) / 256.0);
        m = $rtoi(127.0 * (x < 0.0 ? -x : x) + 0.5);
        return (x < 0.0) ? -m : m;
    endfunction

    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) tw_m[i] = 24'd0;
            acc_m = 24'd0; s_m = 0; gain_m = 0; dac_m = 128; active_m = 1'b0;
        end else begin
            dac_m = 128 + fdiv(s_m * gain_m, 256);
            s_m   = sine_ref(int'(acc_m[23:16]));
            case (bus.mode)
                2'd1:    tsel = tw_m[bus.data_in];
                2'd2:    tsel = tw_m[bus.sym];
                default: tsel = tw_m[0];
            endcase
            acc_m  = bus.sync_clr ? 24'd0 : acc_m + tsel;
            target = (bus.en && (bus.mode != 2'd0 || bus.data_in)) ? 256 : 0;
            if (gain_m < target) gain_m = (gain_m + 1 > target) ? target : gain_m + 1;
            else if (gain_m > target) gain_m = (gain_m - 1 < target) ? target : gain_m - 1;
            active_m = (gain_m != 0);
            if (bus.cfg_we) tw_m[bus.cfg_addr] = bus.cfg_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_tw(input logic [1:0] addr, input logic [23:0] data);
        bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_data = data;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mode = 2'($urandom); bus.en = 1'($urandom); bus.data_in = 1'($urandom);
            bus.sym = 2'($urandom); bus.sync_clr = 1'($urandom);
            bus.cfg_we = 1'($urandom); bus.cfg_addr = 2'($urandom); bus.cfg_data = 24'($urandom);
            tick();
            n_checks++;
            if (bus.dac !== 8'd128 || bus.active !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dac=%0d active=%0b expected dac=128 active=0", bus.dac, bus.active);
            end
        end
        bus.cfg_we = 1'b0; bus.sync_clr = 1'b0; bus.mode = 2'd3; bus.en = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (bus.dac !== 8'd128 || bus.active !== active_m) begin
                n_fail++;
                $display("FAIL reset_tw_zero cyc=%0d dac=%0d active=%0b expected dac=128 active=%0b",
                         i, bus.dac, bus.active, active_m);
            end
        end
    endtask

    task automatic test_cw();
        int exp_seq [5] = '{130, 255, 126, 1, 130};
        write_tw(2'd0, 24'h400000);
        bus.mode = 2'd3; bus.en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            n_checks++;
            if (bus.dac !== dac_m[7:0] || bus.active !== active_m || dut.acc_p0 !== acc_m) begin
                n_fail++;
                $display("FAIL cw_track cyc=%0d dac=%0d active=%0b acc=%h expected dac=%0d active=%0b acc=%h",
                         i, bus.dac, bus.active, dut.acc_p0, dac_m, active_m, acc_m);
            end
        end
        bus.sync_clr = 1'b1;
        tick();
        bus.sync_clr = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.dac !== 8'(exp_seq[i])) begin
                n_fail++;
                $display("FAIL cw_sync_seq idx=%0d dac=%0d expected %0d", i, bus.dac, exp_seq[i]);
            end
        end
    endtask

    task automatic test_ook();
        int cnt;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        bus.mode = 2'd0; bus.en = 1'b1; bus.data_in = 1'b0;
        write_tw(2'd0, 24'h400000);
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (bus.active !== 1'b0 || bus.dac !== 8'd128) begin
            n_fail++;
            $display("FAIL ook_idle active=%0b dac=%0d expected active=0 dac=128", bus.active, bus.dac);
        end
        bus.data_in = 1'b1;
        tick();
        n_checks++;
        if (bus.active !== 1'b1) begin
            n_fail++;
            $display("FAIL ook_active_rise active=%0b expected 1", bus.active);
        end
        for (int i = 0; i < 300; i++) begin
            tick();
            n_checks++;
            if (bus.dac !== dac_m[7:0] || bus.active !== active_m) begin
                n_fail++;
                $display("FAIL ook_ramp_up cyc=%0d dac=%0d active=%0b expected dac=%0d active=%0b",
                         i, bus.dac, bus.active, dac_m, active_m);
            end
        end
        bus.data_in = 1'b0;
        cnt = 0;
        while (bus.active === 1'b1 && cnt < 400) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != 256) begin
            n_fail++;
            $display("FAIL ook_fall_latency cycles=%0d expected 256", cnt);
        end
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (bus.dac !== 8'd128 || bus.active !== 1'b0) begin
            n_fail++;
            $display("FAIL ook_settle dac=%0d active=%0b expected dac=128 active=0", bus.dac, bus.active);
        end
    endtask

    task automatic test_bfsk();
        logic [7:0] hist [16];
        bit         not4;
        write_tw(2'd1, 24'h200000);
        bus.mode = 2'd1; bus.en = 1'b1; bus.data_in = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n_checks++;
            if (bus.dac !== dac_m[7:0] || dut.acc_p0 !== acc_m) begin
                n_fail++;
                $display("FAIL bfsk_mark cyc=%0d dac=%0d acc=%h expected dac=%0d acc=%h",
                         i, bus.dac, dut.acc_p0, dac_m, acc_m);
            end
        end
        bus.data_in = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        for (int i = 0; i < 16; i++) begin
            hist[i] = bus.dac;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (hist[i] !== hist[i+8]) begin
                n_fail++;
                $display("FAIL bfsk_period8 idx=%0d dac=%0d expected %0d", i, hist[i+8], hist[i]);
            end
        end
        not4 = 1'b0;
        for (int i = 0; i < 4; i++) if (hist[i] !== hist[i+4]) not4 = 1'b1;
        n_checks++;
        if (!not4) begin
            n_fail++;
            $display("FAIL bfsk_not_period4 observed=%0b expected 1", not4);
        end
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) bus.data_in = ~bus.data_in;
            tick();
            n_checks++;
            if (bus.dac !== dac_m[7:0] || dut.acc_p0 !== acc_m) begin
                n_fail++;
                $display("FAIL bfsk_toggle cyc=%0d dac=%0d acc=%h expected dac=%0d acc=%h",
                         i, bus.dac, dut.acc_p0, dac_m, acc_m);
            end
        end
    endtask

    task automatic test_mfsk_config();
        logic [23:0] a0;
        logic [23:0] a1;
        bus.mode = 2'd2; bus.en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            write_tw(2'(s), 24'($urandom));
            bus.sym = 2'(s);
            for (int i = 0; i < 30; i++) begin
                tick();
                n_checks++;
                if (bus.dac !== dac_m[7:0] || dut.acc_p0 !== acc_m) begin
                    n_fail++;
                    $display("FAIL mfsk_sym%0d cyc=%0d dac=%0d acc=%h expected dac=%0d acc=%h",
                             s, i, bus.dac, dut.acc_p0, dac_m, acc_m);
                end
            end
        end
        bus.sym = 2'd3;
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'd3; bus.cfg_data = 24'hFFFFF0;
        tick();
        bus.cfg_we = 1'b0;
        a0 = dut.acc_p0;
        tick();
        a1 = dut.acc_p0;
        n_checks++;
        if (24'(a1 - a0) !== 24'hFFFFF0) begin
            n_fail++;
            $display("FAIL mfsk_new_tw_wrap step=%h expected fffff0", 24'(a1 - a0));
        end
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) bus.mode = 2'($urandom);
            if ($urandom_range(0, 4) == 0) bus.data_in = 1'($urandom);
            if ($urandom_range(0, 9) == 0) bus.en = 1'($urandom);
            bus.sym = 2'($urandom);
            bus.sync_clr = ($urandom_range(0, 30) == 0);
            bus.cfg_we = ($urandom_range(0, 9) == 0);
            bus.cfg_addr = 2'($urandom);
            bus.cfg_data = 24'($urandom);
            tick();
            n_checks++;
            if (bus.dac !== dac_m[7:0] || bus.active !== active_m || dut.acc_p0 !== acc_m) begin
                n_fail++;
                $display("FAIL random_mix cyc=%0d dac=%0d active=%0b acc=%h expected dac=%0d active=%0b acc=%h",
                         i, bus.dac, bus.active, dut.acc_p0, dac_m, active_m, acc_m);
            end
        end
        bus.cfg_we = 1'b0; bus.sync_clr = 1'b0;
    endtask

    task automatic test_reset_mid_ramp();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        write_tw(2'd0, 24'h400000);
        bus.mode = 2'd0; bus.en = 1'b1; bus.data_in = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        n_checks++;
        if (bus.active !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ramp_active active=%0b expected 1", bus.active);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (bus.dac !== 8'd128 || bus.active !== 1'b0 || dut.acc_p0 !== 24'd0) begin
            n_fail++;
            $display("FAIL mid_ramp_reset dac=%0d active=%0b acc=%h expected dac=128 active=0 acc=0",
                     bus.dac, bus.active, dut.acc_p0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.mode = 2'd0;
        bus.en = 1'b0; bus.data_in = 1'b0; bus.sym = '0; bus.sync_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_cw();
        test_ook();
        test_bfsk();
        test_mfsk_config();
        test_reset_mid_ramp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
